// File: rtl/pipe_reg_en.sv
// pipe_reg_en: a chain of DEPTH enabled registers, each with its own valid bit.
// The chain has a global stall and a synchronous flush. A stalled output stage
// only blocks the stages behind it when every stage is occupied, so bubbles
// collapse forward.
module pipe_reg_en #(
    parameter int               WIDTH   = 16,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] v_reg;
    logic [WIDTH-1:0] d_reg [DEPTH];

    // r[i]: stage i may load this edge. r[DEPTH] is the downstream acceptance.
    logic [DEPTH:0]   r;

    // What each stage would load: the previous stage, or the input port for stage 0.
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    assign r[DEPTH] = !stall;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage can take new content if it is empty or if its own content moves on.
            assign r[gi] = !v_reg[gi] | r[gi+1];

            if (gi == 0) begin : g_src_port
                assign up_v[gi] = in_valid;
                assign up_d[gi] = in_data;
            end else begin : g_src_prev
                assign up_v[gi] = v_reg[gi-1];
                assign up_d[gi] = d_reg[gi-1];
            end

            // Valid bit: cleared by flush, otherwise follows upstream when this stage is ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_reg[gi] <= 1'b0;
                end else if (flush) begin
                    v_reg[gi] <= 1'b0;
                end else if (r[gi]) begin
                    v_reg[gi] <= up_v[gi];
                end
            end

            // Data: only a real upstream entry overwrites it, and a flush leaves it alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_reg[gi] <= RST_VAL;
                end else if (!flush && r[gi] && up_v[gi]) begin
                    d_reg[gi] <= up_d[gi];
                end
            end
        end
    endgenerate

    // Handshake outputs come straight from the ready chain and the last stage.
    assign in_ready  = r[0] & !flush;
    assign out_valid = v_reg[DEPTH-1];
    assign out_data  = d_reg[DEPTH-1];

    // Occupancy is the number of set valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CW'(v_reg[i]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_en.sv
// Testbench for pipe_reg_en (WIDTH=8, DEPTH=3). The reference model is an
// in-order queue of the entries inside the chain. The stimulus process pushes
// accepted inputs, and a negedge monitor pops and compares consumed outputs.
module tb_pipe_reg_en;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    occupancy;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] q [$];
    logic             xfer;

    pipe_reg_en #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor. It samples mid-cycle, so the values it sees are the
    // ones the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            check("occupancy", 32'(occupancy), 32'(q.size()));
            check("in_ready", 32'(in_ready), 32'(!flush && !(q.size() == DEPTH && stall)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_valid: got 1 required 0 (data %02h)", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(q[0]));
                    if (!stall) begin
                        $display("out %02h", out_data);
                        void'(q.pop_front());
                    end
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;

        // Reset without any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        step();
        rst = 1'b0;

        // Stream three words with no stall.
        in_valid = 1'b1; in_data = 8'h11;
        step(); in_data = 8'h22; #1;
        check("s_occ1", 32'(occupancy), 1);
        check("s_nov1", 32'(out_valid), 0);
        step(); in_data = 8'h33; #1;
        check("s_occ2", 32'(occupancy), 2);
        step(); in_valid = 1'b0; #1;
        check("s_occ3", 32'(occupancy), 3);
        check("s_v11", 32'(out_valid), 1);
        check("s_d11", 32'(out_data), 32'h11);
        step(); #1;
        check("s_d22", 32'(out_data), 32'h22);
        check("s_occ_a", 32'(occupancy), 2);
        step(); #1;
        check("s_d33", 32'(out_data), 32'h33);
        check("s_occ_b", 32'(occupancy), 1);
        step(); #1;
        check("s_empty", 32'(out_valid), 0);

        // Bubble collapse: A1, two idle cycles, then B2, with the output stalled.
        in_valid = 1'b1; in_data = 8'hA1;
        step(); in_valid = 1'b0;
        step();
        step(); in_valid = 1'b1; in_data = 8'hB2; stall = 1'b1; #1;
        check("b_va1", 32'(out_valid), 1);
        check("b_da1", 32'(out_data), 32'hA1);
        check("b_rdy", 32'(in_ready), 1);
        step(); in_valid = 1'b0; #1;
        check("b_occ", 32'(occupancy), 2);
        step(); #1;
        check("b_occ2", 32'(occupancy), 2);
        check("b_hold", 32'(out_data), 32'hA1);
        check("b_rdy2", 32'(in_ready), 1);

        // Full stall: C3 fills the chain, and D4 is refused until the stall releases.
        in_valid = 1'b1; in_data = 8'hC3;
        step(); in_data = 8'hD4; #1;
        check("f_rdy0", 32'(in_ready), 0);
        check("f_occ3", 32'(occupancy), 3);
        step(); #1;
        check("f_rdy0b", 32'(in_ready), 0);
        check("f_hold", 32'(out_data), 32'hA1);
        stall = 1'b0; #1;
        check("f_rdy1", 32'(in_ready), 1);
        step(); in_valid = 1'b0; #1;
        check("f_db2", 32'(out_data), 32'hB2);
        check("f_occ", 32'(occupancy), 3);
        step(); #1;
        check("f_dc3", 32'(out_data), 32'hC3);
        step(); #1;
        check("f_dd4", 32'(out_data), 32'hD4);
        step(); #1;
        check("f_empty", 32'(out_valid), 0);

        // Flush a full, stalled chain while EE is offered at the input.
        stall = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        step(); in_data = 8'h02;
        step(); in_data = 8'h03;
        step(); in_data = 8'hEE; flush = 1'b1; #1;
        check("fl_rdy", 32'(in_ready), 0);
        check("fl_occ3", 32'(occupancy), 3);
        step(); flush = 1'b0; in_valid = 1'b0; stall = 1'b0; #1;
        check("fl_occ0", 32'(occupancy), 0);
        check("fl_nov", 32'(out_valid), 0);
        repeat (4) step();

        // Asynchronous reset mid-stream, then recovery.
        in_valid = 1'b1; in_data = 8'h5A;
        step(); in_data = 8'h5B;
        step(); in_valid = 1'b0;
        step(); #1;
        check("ar_occ2", 32'(occupancy), 2);
        check("ar_v", 32'(out_valid), 1);
        rst = 1'b1; #1;
        check("ar_nov", 32'(out_valid), 0);
        check("ar_d0", 32'(out_data), 0);
        check("ar_occ0", 32'(occupancy), 0);
        step(); rst = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        step(); in_valid = 1'b0;
        step(); #1;
        check("ar_lat", 32'(out_valid), 0);
        step(); #1;
        check("ar_v77", 32'(out_valid), 1);
        check("ar_d77", 32'(out_data), 32'h77);
        step();

        // Random soak. A refused input is held with the same data.
        for (int n = 0; n < 3000; n++) begin
            xfer = in_valid && in_ready;
            step();
            if (!in_valid || xfer) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_data  = WIDTH'($urandom);
            end
            stall = ($urandom_range(0, 99) < 35);
            flush = ($urandom_range(0, 99) < 3);
        end

        // Drain: everything still in flight must come out.
        step();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (DEPTH + 2) step();
        #1;
        check("drain_q", 32'(q.size()), 0);
        check("drain_v", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
